// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART state encodings and baud helpers
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  // Same encodings as the transmitter, so both sides decode state the same way
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_BIT = 3'd1;
  localparam logic [2:0] DATA_BITS = 3'd2;
  localparam logic [2:0] STOP_BIT  = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE      = IDLE,
    RX_START_BIT = START_BIT,
    RX_DATA_BITS = DATA_BITS,
    RX_STOP_BIT  = STOP_BIT,
    RX_WAIT_HIGH = WAIT_HIGH
  } rx_state_e;

  function automatic int clks_per_bit(input int sys_clock, input int baud);
    return sys_clock / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser for one asynchronous input bit
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver with mid-bit sampling and framing-error flag
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  input  logic       i_RxSerial,
  output logic [7:0] o_RxByte,
  output logic       o_RxValid,
  output logic       o_FrameErr,
  output logic       o_Busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLOCK, UART_BAUDRATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [TW-1:0] HALF_M1 = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);

  logic rx_s;

  rx_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (i_SysClock),
    .rst_n   (i_ResetN),
    .i_async (i_RxSerial),
    .o_sync  (rx_s)
  );

  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = RX_START_BIT;
      end

      RX_START_BIT: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          // A start bit that is gone by mid-bit was a glitch
          if (!rx_s) begin
            state_d   = RX_DATA_BITS;
            bit_cnt_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA_BITS: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == BIT_M1) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_STOP_BIT;
        end
      end

      RX_STOP_BIT: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == BIT_M1) begin
          timer_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end

      RX_WAIT_HIGH: begin
        // Swallow a held-low break so it yields only one error pulse
        timer_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end

      default: begin
        state_d = RX_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign o_RxByte   = byte_q;
  assign o_RxValid  = valid_q;
  assign o_FrameErr = ferr_q;
  assign o_Busy     = (state_q != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx (16 clocks per bit)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

  localparam int SYS  = 1600;
  localparam int BAUD = 100;
  localparam int CPB  = 16;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rxd    = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int cyc            = 0;
  int valid_cnt      = 0;
  int err_cnt        = 0;
  int both_cnt       = 0;
  int last_valid_cyc = 0;
  logic [7:0] rx_log[$];

  uart_rx #(
    .SYS_CLOCK     (SYS),
    .UART_BAUDRATE (BAUD)
  ) dut (
    .i_SysClock (clk),
    .i_ResetN   (rst_n),
    .i_RxSerial (rxd),
    .o_RxByte   (rx_byte),
    .o_RxValid  (rx_valid),
    .o_FrameErr (frame_err),
    .o_Busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      rx_log.push_back(rx_byte);
    end
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int bitlen);
    rxd = 1'b0;
    repeat (bitlen) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (bitlen) @(negedge clk);
    end
    rxd = stop;
    repeat (bitlen) @(negedge clk);
  endtask

  function automatic logic [7:0] log_at(input int idx);
    if (idx < rx_log.size()) return rx_log[idx];
    return 8'hxx;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int start_cyc;
    logic [7:0] lb [4];
    lb[0] = 8'h00; lb[1] = 8'h7E; lb[2] = 8'hFF; lb[3] = 8'h12;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_byte",  rx_byte,   0);
    check("reset_valid", rx_valid,  0);
    check("reset_ferr",  frame_err, 0);
    check("reset_busy",  busy,      0);
    rst_n = 1'b1;
    idle(5);

    // Single 0x55 frame with latency: 2 sync + 1 detect + 8 + 144
    start_cyc = cyc;
    send_byte(8'h55, 1'b1, CPB);
    check("single_cnt",     valid_cnt, 1);
    check("single_byte",    rx_byte, 8'h55);
    check("single_log",     log_at(0), 8'h55);
    check("single_latency", last_valid_cyc - start_cyc, 155);
    check("single_noerr",   err_cnt, 0);

    // Back-to-back, zero idle
    send_byte(8'hA3, 1'b1, CPB);
    send_byte(8'h00, 1'b1, CPB);
    send_byte(8'hFF, 1'b1, CPB);
    idle(20);
    check("b2b_cnt",  valid_cnt, 4);
    check("b2b_b0",   log_at(1), 8'hA3);
    check("b2b_b1",   log_at(2), 8'h00);
    check("b2b_b2",   log_at(3), 8'hFF);
    check("b2b_busy", busy, 0);

    // Framing error with held-low break
    send_byte(8'h3C, 1'b0, CPB);
    repeat (100 - CPB) @(negedge clk);
    check("ferr_cnt",       err_cnt, 1);
    check("ferr_novalid",   valid_cnt, 4);
    check("ferr_byte_hold", rx_byte, 8'hFF);
    check("ferr_busy_low",  busy, 1);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("ferr_busy_sync", busy, 1);
    @(negedge clk);
    check("ferr_busy_rel",  busy, 0);
    idle(10);
    send_byte(8'h81, 1'b1, CPB);
    idle(5);
    check("after_ferr_cnt",  valid_cnt, 5);
    check("after_ferr_byte", rx_byte, 8'h81);
    check("after_ferr_err",  err_cnt, 1);

    // 3-cycle glitch
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", busy, 1);
    idle(20);
    check("glitch_idle",  busy, 0);
    check("glitch_valid", valid_cnt, 5);
    check("glitch_err",   err_cnt, 1);
    send_byte(8'h42, 1'b1, CPB);
    idle(5);
    check("after_glitch_cnt",  valid_cnt, 6);
    check("after_glitch_byte", rx_byte, 8'h42);

    // Reset during data bit 4 of 0x99
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'h99 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_byte",  rx_byte, 0);
    check("abort_busy",  busy, 0);
    check("abort_valid", rx_valid, 0);
    rst_n = 1'b1;
    idle(30);
    check("abort_nopulse", valid_cnt, 6);
    check("abort_noerr",   err_cnt, 1);
    check("abort_byte2",   rx_byte, 0);
    send_byte(8'h5A, 1'b1, CPB);
    idle(5);
    check("after_abort_cnt",  valid_cnt, 7);
    check("after_abort_byte", rx_byte, 8'h5A);

    // Loopback-style consecutive stream from a transmitter model
    for (int i = 0; i < 4; i++) send_byte(lb[i], 1'b1, CPB);
    idle(20);
    check("loop_cnt", valid_cnt, 11);
    for (int i = 0; i < 4; i++) check($sformatf("loop_b%0d", i), log_at(7 + i), lb[i]);
    check("loop_noerr", err_cnt, 1);
    check("never_both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side companion to the existing UART transmitter: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial line.
- Sits between the board RX pin and the byte consumer (loopback, command parser).
- Reports each received byte with a single-cycle valid pulse and flags framing errors.
- Same baud parameterisation as the transmitter, so a TX→RX loopback needs no extra configuration.

Parameters:
- SYS_CLOCK, 50000000, system clock frequency in Hz.
- UART_BAUDRATE, 115200, line rate in baud.
- CLKS_PER_BIT, SYS_CLOCK/UART_BAUDRATE (derived, not overridden), clock cycles per bit; 434 at defaults.
- HALF_BIT, CLKS_PER_BIT/2 (derived), offset from start-edge detection to mid-bit sampling point.

Ports:
- i_SysClock  in  1  system clock; all logic on rising edge.
- i_ResetN  in  1  synchronous active-low reset, sampled on rising edge of i_SysClock.
- i_RxSerial  in  1  asynchronous serial input; idles high.
- o_RxByte  out  8  last correctly framed byte; held until the next good frame.
- o_RxValid  out  1  one-cycle pulse: o_RxByte has just been updated.
- o_FrameErr  out  1  one-cycle pulse: stop bit sampled low.
- o_Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (i_ResetN low at a clock edge):
  - Synchroniser flops = 1; state = IDLE; timer = 0; bit count = 0; shift register = 0.
  - o_RxByte = 0x00; o_RxValid = 0; o_FrameErr = 0; o_Busy = 0.
  - Reset asserted mid-frame aborts the frame: no valid or error pulse is produced, and the next byte is received normally after release.
- Input synchronisation: i_RxSerial passes through two flops; all decisions use the second flop (rx_s). Pin-to-rx_s latency is 2 cycles.
- States (3-bit encoding): IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_HIGH.
  - IDLE: timer held at 0. rx_s == 0 → START_BIT. Call that edge cycle t0.
  - START_BIT: timer increments each cycle. When timer == HALF_BIT-1 (cycle t0+HALF_BIT), sample rx_s:
    - rx_s == 0 → DATA_BITS, timer = 0, bit count = 0.
    - rx_s == 1 → glitch; return to IDLE with no pulse.
  - DATA_BITS: timer increments. When timer == CLKS_PER_BIT-1, timer = 0 and rx_s is shifted into shift[7] (shift right), giving LSB-first assembly.
    - Bit count 0..7; the sample taken at count 7 moves the state to STOP_BIT.
    - Samples therefore fall at t0+HALF_BIT+k*CLKS_PER_BIT, k = 1..8.
  - STOP_BIT: when timer == CLKS_PER_BIT-1 (t0+HALF_BIT+9*CLKS_PER_BIT):
    - rx_s == 1 → o_RxByte = shift, o_RxValid = 1 for exactly the next cycle, state → IDLE.
    - rx_s == 0 → o_FrameErr = 1 for one cycle, o_RxByte unchanged, state → WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s == 1, then → IDLE. A held-low (break) line produces exactly one error pulse, not a stream.
- Back-to-back frames: the return to IDLE happens mid stop bit, so a start edge immediately following the stop bit is detected. Zero idle time between frames is supported.
- o_RxValid and o_FrameErr are never high in the same cycle. Both are registered outputs.
- Timer width: $clog2(CLKS_PER_BIT)+1 bits. Comparisons are exact equality; the timer never wraps.
- Tolerance: the mid-bit sampling point tolerates ±4% cumulative baud mismatch, which covers a transmitter whose bit period is CLKS_PER_BIT+1 cycles.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (IDLE..WAIT_HIGH), shared with the TX-side encodings;
  - function clks_per_bit(sys_clock, baud).
- Sub-module sync_2ff (1-bit, reset value parameterised, synchronous active-low reset) for the input synchroniser. It is reusable for other async pins.
- Everything else stays in one module.

Test Plan (bench uses SYS_CLOCK=1600, UART_BAUDRATE=100 → CLKS_PER_BIT=16, HALF_BIT=8):
- Single frame 0x55 driven at 16 clk/bit → exactly one o_RxValid pulse, o_RxByte=0x55, o_FrameErr never high, pulse at t0+8+144+1 relative to the rx_s falling edge.
- Frames 0xA3, 0x00 and 0xFF back-to-back with zero idle → three valid pulses in order, with bytes 0xA3, 0x00, 0xFF.
- Frame 0x3C with stop bit driven low, then line held low 100 cycles, then high → one o_FrameErr pulse, o_RxByte keeps its previous value, no o_RxValid; o_Busy stays high until rx_s returns high. A following frame 0x81 is received correctly.
- 3-cycle low glitch on an idle line → returns to IDLE after the START_BIT sample, no pulses; a subsequent 0x42 frame is received.
- i_ResetN asserted for 2 cycles during data bit 4 of 0x99 → no pulses, outputs back to reset values. The next frame 0x5A is received correctly.
- Loopback with the transmitter at the same parameters, sending 0x00, 0x7E, 0xFF, 0x12 consecutively → four matching valid pulses and zero framing errors.
